seq_monitor_n: RTL
==================

SEQ_MONITOR_N -- requirements
Module: seq_monitor_n

Interface
REQ-001 The block SHALL have parameter DIN_W, default 4, giving the input sample width.
REQ-002 The block SHALL have parameter Q_W, default 8, giving the output code width; Q_W SHALL be even and at least 2.
REQ-003 The block SHALL have parameter RUN_LEN, default 4, giving the step count that enters ALERT.
REQ-004 The block SHALL have parameter SAT_LEN, default 8, giving the step count that enters SAT; 1 <= RUN_LEN < SAT_LEN <= 255.
REQ-005 The block SHALL have parameter HOLD_CYC, default 3, giving the post-saturation hold length in clocks; HOLD_CYC >= 1.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 arst_in  in  1  reset, asynchronous, active-high.
REQ-008 din_valid  in  1  qualifies din for the current clock.
REQ-009 din  in  DIN_W  sample value.
REQ-010 mode  in  1  step direction: 0 = ascending (+1), 1 = descending (-1).
REQ-011 q  out  Q_W  registered status code.
REQ-012 run_cnt  out  8  registered count of consecutive matching steps, saturating at 255.
REQ-013 det_pulse  out  1  registered one-clock alert strobe.

Function
REQ-014 A "match" SHALL be defined as a valid sample, with prev_valid set, where din == prev + 1 (mode 0) or din == prev - 1 (mode 1), both computed modulo 2^DIN_W.
REQ-015 A "mismatch" SHALL be defined as a valid sample, with prev_valid set, that is not a match.
REQ-016 On every valid sample, prev SHALL load din and prev_valid SHALL set.
REQ-017 The first valid sample after reset SHALL be neither a match nor a mismatch.
REQ-018 With din_valid low, prev, run_cnt and the state SHALL hold, except for the HOLD timer (REQ-025).
REQ-019 run_cnt SHALL increment on a match (saturating at 255) and clear to 0 on a mismatch.
REQ-020 mode SHALL be sampled per sample; a mode change mid-run affects only later comparisons.
REQ-021 Wrap-around SHALL count as a step: all-ones -> 0 in mode 0, and 0 -> all-ones in mode 1.
REQ-022 The state machine SHALL have states IDLE, TRACK, ALERT, SAT and HOLD.
REQ-023 q per state SHALL be: IDLE and TRACK = all zeros; ALERT = alternating pattern {Q_W/2{2'b01}} (0x55 at Q_W=8); SAT and HOLD = all ones.
REQ-024 Transitions SHALL be evaluated with the updated run_cnt value:
- IDLE -> TRACK on a match.
- TRACK -> ALERT when run_cnt reaches RUN_LEN; TRACK -> IDLE on a mismatch.
- ALERT -> SAT when run_cnt reaches SAT_LEN; ALERT -> IDLE on a mismatch.
- SAT stays in SAT on a match; SAT -> HOLD on a mismatch, loading the hold timer with HOLD_CYC.
REQ-025 In HOLD, the hold timer SHALL decrement every clock regardless of din_valid.
REQ-026 At hold-timer expiry (the HOLD_CYC-th clock in HOLD), the state SHALL go to IDLE and run_cnt SHALL clear; prev is retained.
REQ-027 Matches in HOLD SHALL update run_cnt and prev but SHALL NOT change the state.
REQ-028 With RUN_LEN = 1, IDLE SHALL go directly to ALERT on the first match, skipping TRACK.
REQ-029 det_pulse SHALL be high for exactly the one clock following any transition into ALERT, and low otherwise.
REQ-030 All outputs SHALL be registered; a sample presented before edge N SHALL be reflected on q, run_cnt and det_pulse after edge N (one-clock latency).

Reset
REQ-031 While arst_in is high, q SHALL be all zeros, run_cnt 0, det_pulse 0, state IDLE, prev_valid 0 and the hold timer 0, asynchronously and independent of clk.
REQ-032 Assertion of arst_in mid-operation (any state, including between edges) SHALL force the REQ-031 values immediately.
REQ-033 After arst_in is released, the first valid sample SHALL be treated as the first sample (REQ-017).

Verification (defaults DIN_W=4, Q_W=8, RUN_LEN=4, SAT_LEN=8, HOLD_CYC=3)
REQ-034 Reset with clk running -> q=0x00, run_cnt=0, det_pulse=0.
REQ-035 mode 0, din 0,1,2,3,4 on consecutive clocks -> run_cnt=4, q=0x55 after the din=4 edge, det_pulse high for exactly one clock.
REQ-036 Continue with din 5..8, then din=3 -> q=0xFF from the din=8 edge, q stays 0xFF for 3 clocks after the mismatch, then q=0x00 and run_cnt=0.
REQ-037 mode 1, din 2,1,0,F,E -> q=0x55, run_cnt=4 (descending wrap counted).
REQ-038 In TRACK with run_cnt=2, din_valid low for 5 clocks, then din continues the run -> no change while paused, ALERT reached after 2 more matches.
REQ-039 In SAT, arst_in pulsed between clock edges -> q=0x00 immediately; the next sample (din=7) gives run_cnt=0, state IDLE.

Source files
------------

// File: rtl/seq_monitor_n.sv
// seq_monitor_n: watches a sample stream for runs of +1/-1 steps and reports
// IDLE/TRACK/ALERT/SAT/HOLD status with a registered code, run count and alert strobe.
`default_nettype none

module seq_monitor_n #(
  parameter int DIN_W    = 4,
  parameter int Q_W      = 8,
  parameter int RUN_LEN  = 4,
  parameter int SAT_LEN  = 8,
  parameter int HOLD_CYC = 3
) (
  input  logic             clk,
  input  logic             arst_in,
  input  logic             din_valid,
  input  logic [DIN_W-1:0] din,
  input  logic             mode,
  output logic [Q_W-1:0]   q,
  output logic [7:0]       run_cnt,
  output logic             det_pulse
);

  localparam int HT_W = $clog2(HOLD_CYC + 1);

  localparam logic [Q_W-1:0]  c_Q_ZERO   = '0;
  localparam logic [Q_W-1:0]  c_Q_ALERT  = {(Q_W/2){2'b01}};
  localparam logic [Q_W-1:0]  c_Q_ONES   = '1;
  localparam logic [HT_W-1:0] c_HOLD_LD  = HT_W'(HOLD_CYC);
  localparam logic [7:0]      c_RUN_LEN  = 8'(RUN_LEN);
  localparam logic [7:0]      c_SAT_LEN  = 8'(SAT_LEN);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TRACK = 3'd1,
    ST_ALERT = 3'd2,
    ST_SAT   = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DIN_W-1:0] prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [HT_W-1:0]  hold_q, hold_d;
  logic [Q_W-1:0]   q_q, q_d;
  logic             det_q, det_d;

  logic [DIN_W-1:0] w_expect;
  logic             w_cmp;
  logic             w_match;
  logic             w_mismatch;

  // Expected next value wraps naturally at DIN_W bits, so wrap-around counts as a step.
  assign w_expect   = mode ? (prev_q - DIN_W'(1)) : (prev_q + DIN_W'(1));
  assign w_cmp      = din_valid && prev_valid_q;
  assign w_match    = w_cmp && (din == w_expect);
  assign w_mismatch = w_cmp && (din != w_expect);

  always_comb begin
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    cnt_d        = cnt_q;
    state_d      = state_q;
    hold_d       = hold_q;

    if (din_valid) begin
      prev_d       = din;
      prev_valid_d = 1'b1;
    end

    if (w_match) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);
    end else if (w_mismatch) begin
      cnt_d = 8'd0;
    end

    // Transitions look at the already-updated count.
    case (state_q)
      ST_IDLE: begin
        if (w_match) begin
          state_d = (cnt_d >= c_RUN_LEN) ? ST_ALERT : ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (w_mismatch) begin
          state_d = ST_IDLE;
        end else if (w_match && (cnt_d >= c_RUN_LEN)) begin
          state_d = ST_ALERT;
        end
      end
      ST_ALERT: begin
        if (w_mismatch) begin
          state_d = ST_IDLE;
        end else if (w_match && (cnt_d >= c_SAT_LEN)) begin
          state_d = ST_SAT;
        end
      end
      ST_SAT: begin
        if (w_mismatch) begin
          state_d = ST_HOLD;
          hold_d  = c_HOLD_LD;
        end
      end
      ST_HOLD: begin
        // Expiry overrides any sample arriving on the same clock.
        if (hold_q <= HT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q - HT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase

    case (state_d)
      ST_ALERT:        q_d = c_Q_ALERT;
      ST_SAT, ST_HOLD: q_d = c_Q_ONES;
      default:         q_d = c_Q_ZERO;
    endcase

    det_d = (state_d == ST_ALERT) && (state_q != ST_ALERT);
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      cnt_q        <= 8'd0;
      hold_q       <= '0;
      q_q          <= c_Q_ZERO;
      det_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      q_q          <= q_d;
      det_q        <= det_d;
    end
  end

  assign q         = q_q;
  assign run_cnt   = cnt_q;
  assign det_pulse = det_q;

endmodule

`default_nettype wire
